// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the datamem line-port arbiter.
package mem_arb_pkg;

  localparam int unsigned LINE_WIDTH  = 128;
  localparam int unsigned OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the prio side.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic prio_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = req_i_i | req_d_i;
    winner_o = REQ_I;
    if (req_i_i && req_d_i) begin
      winner_o = prio_i;
    end else if (req_d_i) begin
      winner_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-side line reads and D-side line reads/writes onto the single
// datamem line port, one transaction in flight, zero-bubble back-to-back grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = mem_arb_pkg::LINE_WIDTH,
  parameter int unsigned OFFSET_BITS = mem_arb_pkg::OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_readdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_writedata,
  output logic [LINE_WIDTH-1:0] d_readdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [LINE_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WIDTH-1:0] mem_readdata,
  input  logic                  mem_ready
);

  arb_state_t            state_q, state_d;
  requester_t            prio_q, prio_d;
  logic                  mem_req_q, mem_req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic arb_point;
  logic req_i_m, req_d_m;
  logic gnt_valid, winner;

  assign arb_point = (state_q == IDLE) || mem_ready;
  // The completing side still holds its request this cycle; mask it so it
  // is not served twice.
  assign req_i_m = i_req && (state_q != GRANT_I);
  assign req_d_m = d_req && (state_q != GRANT_D);

  mem_arb_rr u_rr (
    .req_i_i  (req_i_m),
    .req_d_i  (req_d_m),
    .prio_i   (prio_q),
    .valid_o  (gnt_valid),
    .winner_o (winner)
  );

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    mem_req_d = mem_req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (arb_point) begin
      if (gnt_valid) begin
        mem_req_d = 1'b1;
        if (winner == REQ_D) begin
          state_d = GRANT_D;
          prio_d  = REQ_I;
          we_d    = d_we;
          addr_d  = {d_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          wdata_d = d_writedata;
        end else begin
          state_d = GRANT_I;
          prio_d  = REQ_D;
          we_d    = 1'b0;
          addr_d  = {i_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        end
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      prio_q    <= REQ_D;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      mem_req_q <= mem_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign WriteEnable    = we_q;
  assign memory_address = addr_q;
  assign mem_writedata  = wdata_q;

  assign i_ready    = (state_q == GRANT_I) && mem_ready;
  assign d_ready    = (state_q == GRANT_D) && mem_ready;
  assign i_readdata = mem_readdata;
  assign d_readdata = mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected line
// transactions, a monitor pops and checks them on every *_ready pulse.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_writedata, i_readdata, d_readdata;
  logic          i_ready, d_ready;
  logic          mem_req, WriteEnable, mem_ready;
  logic [AW-1:0] memory_address;
  logic [LW-1:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_readdata     (i_readdata),
    .i_ready        (i_ready),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_writedata    (d_writedata),
    .d_readdata     (d_readdata),
    .d_ready        (d_ready),
    .mem_req        (mem_req),
    .WriteEnable    (WriteEnable),
    .memory_address (memory_address),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_ready      (mem_ready)
  );

  typedef struct {
    requester_t    side;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   rsp_en = 1'b0;
  bit   contention_active = 1'b0;
  int   rsp_cnt = 0;
  localparam int LAT = 3;

  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [LW-1:0] prev_wdata;
  logic          prev_we;

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic checkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // datamem model: completes each mem_req after LAT observed cycles
  initial begin
    mem_ready    = 1'b0;
    mem_readdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rsp_en) begin
        mem_ready = 1'b0;
        if (!rst || !mem_req) begin
          rsp_cnt = 0;
        end else begin
          rsp_cnt++;
          if (rsp_cnt == LAT) begin
            mem_ready    = 1'b1;
            mem_readdata = (exp_q.size() != 0) ? exp_q[0].rdata : '0;
            rsp_cnt      = 0;
          end
        end
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        check1("ready_exclusive", i_ready & d_ready, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready: i_ready=%b d_ready=%b want none", i_ready, d_ready);
        end else begin
          mon_e = exp_q.pop_front();
          check1("grant_side", d_ready, mon_e.side == REQ_D);
          checkw("mem_addr", LW'(memory_address), LW'(mon_e.addr));
          check1("write_enable", WriteEnable, mon_e.we);
          if (mon_e.we) checkw("mem_wdata", mem_writedata, mon_e.wdata);
          checkw("i_readdata", i_readdata, mon_e.rdata);
          checkw("d_readdata", d_readdata, mon_e.rdata);
        end
      end
      if (prev_hold) begin
        check1("hold_req", mem_req, 1'b1);
        checkw("hold_addr", LW'(memory_address), LW'(prev_addr));
        check1("hold_we", WriteEnable, prev_we);
        checkw("hold_wdata", mem_writedata, prev_wdata);
      end
      if (contention_active) check1("no_bubble", mem_req, 1'b1);
      prev_hold  = rst && mem_req && !mem_ready && !i_ready && !d_ready;
      prev_addr  = memory_address;
      prev_we    = WriteEnable;
      prev_wdata = mem_writedata;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input requester_t s, input logic w, input logic [AW-1:0] a,
                      input logic [LW-1:0] wd, input logic [LW-1:0] rd);
    exp_t e;
    e.side = s; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input requester_t side, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if ((side == REQ_I) ? i_ready : d_ready) begin
        seen = 1'b1;
        if (side == REQ_I) i_req = 1'b0;
        else d_req = 1'b0;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: no ready within 40 cycles, got 0 want 1", name);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: pending=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_writedata = '0;
    rsp_en = 1'b1;

    // reset with d_req held, first grant goes to D
    d_req  = 1'b1;
    d_addr = 32'h0000_2008;
    tick(2);
    @(negedge clk);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_we", WriteEnable, 1'b0);
    checkw("rst_addr", LW'(memory_address), '0);
    checkw("rst_wdata", mem_writedata, '0);
    check1("rst_i_ready", i_ready, 1'b0);
    check1("rst_d_ready", d_ready, 1'b0);
    push(REQ_D, 1'b0, 32'h0000_2000, '0, {4{32'h1111_2222}});
    tick(1);
    rst = 1'b1;
    wait_ready(REQ_D, "first_grant_d");
    drain("first_grant_d");

    // lone I read
    tick(1);
    i_addr = 32'h0000_1234;
    i_req  = 1'b1;
    push(REQ_I, 1'b0, 32'h0000_1230, '0, {16{8'hA5}});
    @(negedge clk);
    check1("i_req_latency_n", mem_req, 1'b0);
    @(negedge clk);
    check1("i_req_latency_n1", mem_req, 1'b1);
    checkw("i_addr_n1", LW'(memory_address), LW'(32'h0000_1230));
    check1("i_we_n1", WriteEnable, 1'b0);
    wait_ready(REQ_I, "lone_i_read");
    drain("lone_i_read");

    // D write
    tick(1);
    d_we        = 1'b1;
    d_addr      = 32'h0001_0000;
    d_writedata = 128'h0123456789ABCDEF0123456789ABCDEF;
    d_req       = 1'b1;
    push(REQ_D, 1'b1, 32'h0001_0000, 128'h0123456789ABCDEF0123456789ABCDEF, {8{16'h5A5A}});
    @(negedge clk);
    @(negedge clk);
    check1("d_we_n1", WriteEnable, 1'b1);
    wait_ready(REQ_D, "d_write");
    drain("d_write");
    d_we = 1'b0;

    // contention from reset: D, I, D, I with no gap on mem_req
    tick(1);
    rst    = 1'b0;
    i_addr = 32'h0000_4004;
    d_addr = 32'h0000_800C;
    i_req  = 1'b1;
    d_req  = 1'b1;
    push(REQ_D, 1'b0, 32'h0000_8000, '0, {4{32'hD0D0_0001}});
    push(REQ_I, 1'b0, 32'h0000_4000, '0, {4{32'h1010_0002}});
    push(REQ_D, 1'b0, 32'h0000_8000, '0, {4{32'hD0D0_0003}});
    push(REQ_I, 1'b0, 32'h0000_4000, '0, {4{32'h1010_0004}});
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check1("contend_start", mem_req, 1'b1);
    contention_active = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      if (i_ready || d_ready) n++;
      if (n < 4) @(negedge clk);
    end
    contention_active = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    drain("contention");

    // spurious mem_ready in IDLE
    rsp_en = 1'b0;
    tick(2);
    mem_ready    = 1'b1;
    mem_readdata = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    check1("idle_i_ready", i_ready, 1'b0);
    check1("idle_d_ready", d_ready, 1'b0);
    tick(1);
    mem_ready = 1'b0;
    @(negedge clk);
    check1("idle_stays", mem_req, 1'b0);

    // reset in the middle of a D grant
    tick(1);
    d_we        = 1'b1;
    d_addr      = 32'h0000_0300;
    d_writedata = {4{32'hCAFE_F00D}};
    d_req       = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check1("midrst_grant", seen, 1'b1);
    tick(2);
    rst   = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("midrst_mem_req", mem_req, 1'b0);
    check1("midrst_we", WriteEnable, 1'b0);
    checkw("midrst_addr", LW'(memory_address), '0);
    rst       = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check1("midrst_no_d_ready", d_ready, 1'b0);
    tick(1);
    mem_ready = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
